// File: rtl/down_counter_ctrl_if.sv
// Handshake/status bundle between a sequencer client and down_counter_ctrl.
// master drives commands and the load value; slave is the controller side.
interface down_counter_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] load_val;
   logic             auto_reload;
   logic [WIDTH-1:0] cnt;
   logic             tc;
   logic             busy;
   logic             done;

   modport master (
      output start, pause, abort, load_val, auto_reload,
      input  cnt, tc, busy, done
   );

   modport slave (
      input  start, pause, abort, load_val, auto_reload,
      output cnt, tc, busy, done
   );
endinterface

// File: rtl/down_counter_ctrl.sv
// Load / count-down / stop-or-reload sequencer with pause, resume and abort.
// Define DCNT_PRESCALE_EN to advance the count once every PRESCALE cycles in RUN.
module down_counter_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input logic                clk,
   input logic                rst,
   down_counter_ctrl_if.slave ctrl
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             mode_q, mode_d;
   logic             tc_q, tc_d;
   logic             tick;

`ifdef DCNT_PRESCALE_EN
   localparam int PS_W = $clog2(PRESCALE);

   logic [PS_W-1:0] presc_q, presc_d;

   assign tick = (state_q == RUN) && (presc_q == PS_W'(PRESCALE - 1));

   // Parked at zero outside RUN/PAUSE so every fresh run starts a full interval.
   always_comb begin
      presc_d = presc_q;
      if (ctrl.abort || state_q == IDLE || state_q == DONE) begin
         presc_d = '0;
      end else if (state_q == RUN && !ctrl.pause) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   logic unused_prescale;

   assign tick            = (state_q == RUN);
   assign unused_prescale = (PRESCALE != 0);
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      tc_d     = 1'b0;

      if (ctrl.abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (ctrl.start) begin
                  if (ctrl.load_val != '0) begin
                     cnt_d    = ctrl.load_val;
                     reload_d = ctrl.load_val;
                     mode_d   = ctrl.auto_reload;
                     state_d  = RUN;
                  end else begin
                     // A zero load right after a terminal count must not stretch tc to two cycles.
                     cnt_d   = '0;
                     tc_d    = !tc_q;
                     state_d = DONE;
                  end
               end
            end
            RUN: begin
               if (ctrl.pause) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  if (cnt_q > WIDTH'(1)) begin
                     cnt_d = cnt_q - 1'b1;
                  end else if (cnt_q == WIDTH'(1)) begin
                     cnt_d = '0;
                     tc_d  = 1'b1;
                     if (!mode_q) begin
                        state_d = DONE;
                     end
                  end else begin
                     cnt_d = reload_q;
                  end
               end
            end
            PAUSE: begin
               if (ctrl.start) begin
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '1;
         reload_q <= '1;
         mode_q   <= 1'b0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         tc_q     <= tc_d;
      end
   end

   assign ctrl.cnt  = cnt_q;
   assign ctrl.tc   = tc_q;
   assign ctrl.busy = (state_q == RUN) || (state_q == PAUSE);
   assign ctrl.done = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed-vector bench for down_counter_ctrl; expected values are hand-computed.
// Builds with or without DCNT_PRESCALE_EN (PRESCALE=4 in the prescaled build).
module tb_down_counter_ctrl;

   localparam int WIDTH    = 4;
   localparam int PRESCALE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   down_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

   down_counter_ctrl #(
      .WIDTH    (WIDTH),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .ctrl (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input int c, input bit t, input bit b, input bit d);
      check({tag, "_cnt"},  32'(bus.cnt),  32'(c));
      check({tag, "_tc"},   32'(bus.tc),   32'(t));
      check({tag, "_busy"}, 32'(bus.busy), 32'(b));
      check({tag, "_done"}, 32'(bus.done), 32'(d));
   endtask

   // Advance one edge and sample #1 later; inputs set after a step apply to the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
      bus.load_val = '0; bus.auto_reload = 1'b0;

      // Reset for two edges with inputs toggled during the second.
      step();
      bus.start = 1'b1; bus.load_val = 4'd5; bus.auto_reload = 1'b1; bus.pause = 1'b1;
      step();
      check_out("rst", 15, 0, 0, 0);
      rst = 1'b0;
      bus.start = 1'b0; bus.pause = 1'b0; bus.auto_reload = 1'b0;
      step();
      check_out("idle", 15, 0, 0, 0);

`ifndef DCNT_PRESCALE_EN
      // One-shot count 3,2,1,0 then DONE.
      bus.start = 1'b1; bus.load_val = 4'd3; bus.auto_reload = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         bus.start = 1'b0;
         check_out($sformatf("oneshot%0d", i), 3 - i, i == 3, i != 3, i == 3);
      end
      step();
      check_out("done_hold", 0, 0, 0, 1);

      // Auto-reload: 2,1,0,2,1,0,2 with tc on each 0.
      bus.start = 1'b1; bus.load_val = 4'd2; bus.auto_reload = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         bus.start = 1'b0;
         check_out($sformatf("reload%0d", i), 2 - (i % 3), (i % 3) == 2, 1, 0);
      end
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check_out("abort_reload", 2, 0, 0, 0);

      // Pause for three cycles at 5, resume without reload.
      bus.start = 1'b1; bus.load_val = 4'd7; bus.auto_reload = 1'b0;
      step();
      bus.start = 1'b0;
      check_out("p_load", 7, 0, 1, 0);
      step();
      step();
      check_out("p_five", 5, 0, 1, 0);
      bus.pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         bus.pause = 1'b0;
         check_out($sformatf("p_hold%0d", i), 5, 0, 1, 0);
      end
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check_out("p_resume", 5, 0, 1, 0);
      step();
      check_out("p_four", 4, 0, 1, 0);
      step();
      check_out("p_three", 3, 0, 1, 0);

      // Pause and start together in RUN: pause wins.
      bus.pause = 1'b1; bus.start = 1'b1;
      step();
      bus.pause = 1'b0; bus.start = 1'b0;
      check_out("ps_both", 3, 0, 1, 0);
      step();
      check_out("ps_held", 3, 0, 1, 0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      check_out("ps_two", 2, 0, 1, 0);
      step();
      check_out("ps_one", 1, 0, 1, 0);

      // Abort on the 1->0 edge: cnt holds 1, no tc.
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check_out("abort_tc", 1, 0, 0, 0);
      step();
      check_out("abort_idle", 1, 0, 0, 0);

      // Zero load: immediate DONE with a single tc, even when auto_reload is set.
      bus.start = 1'b1; bus.load_val = 4'd0; bus.auto_reload = 1'b1;
      step();
      bus.start = 1'b0;
      check_out("zero_load", 0, 1, 0, 1);
      step();
      check_out("zero_hold", 0, 0, 0, 1);

      // Terminal count followed at once by a zero load: tc must not repeat.
      bus.start = 1'b1; bus.load_val = 4'd1; bus.auto_reload = 1'b0;
      step();
      check_out("b2b_load", 1, 0, 1, 0);
      bus.load_val = 4'd0;
      step();
      check_out("b2b_tc", 0, 1, 0, 1);
      step();
      bus.start = 1'b0;
      check_out("b2b_notc", 0, 0, 0, 1);

      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check_out("abort_done", 0, 0, 0, 0);

      // Reset in the middle of a run.
      bus.start = 1'b1; bus.load_val = 4'd9; bus.auto_reload = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      check_out("mid_run", 8, 0, 1, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_out("mid_rst", 15, 0, 0, 0);
      step();
      check_out("post_rst", 15, 0, 0, 0);
`else
      // Prescaled one-shot: 2 for four cycles, 1 for four cycles, then 0 with tc.
      bus.start = 1'b1; bus.load_val = 4'd2; bus.auto_reload = 1'b0;
      for (int i = 0; i < 9; i++) begin
         step();
         bus.start = 1'b0;
         check_out($sformatf("pre%0d", i), 2 - (i / 4), i == 8, i != 8, i == 8);
      end

      // Three non-counting edges mid-interval push the first tick from E4 to E7.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      bus.pause = 1'b1;
      step();
      bus.pause = 1'b0;
      check_out("pp_pause", 2, 0, 1, 0);
      step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check_out("pp_resume", 2, 0, 1, 0);
      step();
      step();
      check_out("pp_e6", 2, 0, 1, 0);
      step();
      check_out("pp_e7", 1, 0, 1, 0);
      step();
      step();
      step();
      check_out("pp_e10", 1, 0, 1, 0);
      step();
      check_out("pp_e11", 0, 1, 0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
